// File: rtl/fpu_pkg.sv
// Shared FPU constants: default tag width and requester identifiers.
package fpu_pkg;
    localparam int   TAG_W_DEF = 5;
    localparam logic SRC_0     = 1'b0;
    localparam logic SRC_1     = 1'b1;
endpackage

// File: rtl/itof.sv
// Combinational int32 -> IEEE-754 single conversion, truncating.
module itof (
    input  logic [31:0] x,
    output logic [31:0] y
);
    logic        w_s;
    logic [31:0] w_mag;
    logic [4:0]  w_msb;
    logic [31:0] w_norm;

    always_comb begin
        w_s   = x[31];
        w_mag = w_s ? (~x + 32'd1) : x;
        w_msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (w_mag[i]) w_msb = i[4:0];
        end
        // Leading one lands at bit 31; bits below it are the fraction.
        w_norm = w_mag << (5'd31 - w_msb);
        y = '0;
        if (w_mag != 32'd0) begin
            y = {w_s, 8'd127 + {3'b000, w_msb}, w_norm[30:8]};
        end
    end
endmodule

// File: rtl/itof_arb.sv
// Two requesters share one itof converter via a 2-stage pipeline
// with round-robin arbitration and valid/ready handshakes.
module itof_arb
    import fpu_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag
);
    logic             r_s1_valid;
    logic [31:0]      r_s1_x;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_src;
    logic             r_s2_valid;
    logic [31:0]      r_y;
    logic [TAG_W-1:0] r_tag;
    logic             r_src;
    logic             r_last;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_g0;
    logic             w_g1;
    logic             w_acc;
    logic [31:0]      w_y;

    assign w_adv2 = !r_s2_valid | out_ready;
    assign w_adv1 = !r_s1_valid | w_adv2;

    // Grant depends only on valids and the pointer, never on ready.
    assign w_g1 = req1_valid & (!req0_valid | (r_last == SRC_0));
    assign w_g0 = req0_valid & !w_g1;

    assign req0_ready = w_g0 & w_adv1 & !rst;
    assign req1_ready = w_g1 & w_adv1 & !rst;
    assign w_acc      = req0_ready | req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_tag   <= '0;
            r_s1_src   <= SRC_0;
            r_last     <= SRC_1;
        end else if (w_adv1) begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_x   <= w_g1 ? req1_x : req0_x;
                r_s1_tag <= w_g1 ? req1_tag : req0_tag;
                r_s1_src <= w_g1 ? SRC_1 : SRC_0;
                r_last   <= w_g1 ? SRC_1 : SRC_0;
            end
        end
    end

    itof u_itof (
        .x (r_s1_x),
        .y (w_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_tag      <= '0;
            r_src      <= SRC_0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y   <= w_y;
                r_tag <= r_s1_tag;
                r_src <= r_s1_src;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_y     = r_y;
    assign out_tag   = r_tag;
    assign out_src   = r_src;
endmodule

// File: doc/itof_arb.md
ITOF_ARB -- requirements
Module: itof_arb

Interface
REQ-001 SHALL have parameter: TAG_W, 5, width of destination-register tag carried with each conversion.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester 0/1 offers an operand.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  operand accepted this cycle when valid&ready.
REQ-006 SHALL have ports: req0_x / req1_x  input  32  signed two's-complement integer to convert.
REQ-007 SHALL have ports: req0_tag / req1_tag  input  TAG_W  destination tag, returned unchanged.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result when out_valid&out_ready.
REQ-010 SHALL have port: out_y  output  32  IEEE-754 single result.
REQ-011 SHALL have ports: out_src  output  1 (requester id); out_tag  output  TAG_W (tag of that request).

Function
REQ-012 SHALL share one itof converter between the two requesters through a 2-stage pipeline: S1 (operand, tag, src registered) -> itof (combinational) -> S2 (out_y/out_tag/out_src registered).
REQ-013 SHALL compute out_y equal to itof(x) of the accepted operand: truncating, no rounding; 0 -> 0x00000000.
REQ-014 SHALL define advance2 = !s2_valid | out_ready and advance1 = !s1_valid | advance2; S1 loads only when advance1.
REQ-015 SHALL assert at most one reqN_ready per cycle; reqN_ready = grantN & advance1, with grant independent of reqN_ready (no combinational loop through ready).
REQ-016 SHALL arbitrate round-robin: single requester valid -> granted; both valid -> grant the one not granted last; pointer updates only on an accepted transfer.
REQ-017 SHALL give latency 2: operand accepted at edge N appears with out_valid=1 after edge N+1 when pipeline not stalled.
REQ-018 SHALL sustain throughput 1 conversion/cycle with out_ready held high.
REQ-019 SHALL hold out_valid, out_y, out_tag, out_src stable while out_valid & !out_ready; S1 holds while S2 is stalled; no result dropped or duplicated.
REQ-020 SHALL deliver results in acceptance order, each exactly once.
REQ-021 SHALL allow S2 to drain and S1 to load in the same cycle (simultaneous accept and consume).

Reset
REQ-022 SHALL, on rst=1, asynchronously clear s1_valid, s2_valid (out_valid=0), req0_ready=req1_ready=0, out_y=0, out_tag=0, out_src=0, and set round-robin pointer so requester 0 wins the first tie.
REQ-023 SHALL discard in-flight conversions when reset asserts mid-operation; no result emitted for them after release.

Structure
REQ-024 SHALL place TAG_W default and the requester-id constants (SRC_0=0, SRC_1=1) in shared package fpu_pkg.
REQ-025 SHALL instantiate existing sub-module itof (x in 32, y out 32) once between S1 and S2; no other sub-modules.

Verification
REQ-026 SHALL cover: req0 x=1 tag=3, out_ready=1 -> 2 cycles later out_y=0x3F800000, out_tag=3, out_src=0.
REQ-027 SHALL cover: req1 x=3 then x=-1 back-to-back -> out_y=0x40400000 then 0xBF800000 on consecutive cycles, out_src=1.
REQ-028 SHALL cover: both valid for 4 cycles from reset (req0 x=0, req1 x=16777217) -> grants 0,1,0,1; results 0x00000000, 0x4B800000 alternating.
REQ-029 SHALL cover: out_ready=0 for 5 cycles with 3 requests offered -> out_valid stays 1 with first result stable, exactly 2 accepted, then all 3 delivered in order after out_ready=1.
REQ-030 SHALL cover: rst asserted with S1 and S2 full -> out_valid=0 immediately; after release no stale result appears and req0 wins first tie.
